// File: rtl/mipi_tx_pkg.sv
// Shared types and constants for the MIPI CSI-2 TX generic-frame test generator.
package mipi_tx_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_SOLID = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBLANK = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } state_e;

    localparam logic [5:0]  TYPE_RGB888 = 6'h24;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_rgb = BAR_WHITE;
            3'd1:    bar_rgb = BAR_YELLOW;
            3'd2:    bar_rgb = BAR_CYAN;
            3'd3:    bar_rgb = BAR_GREEN;
            3'd4:    bar_rgb = BAR_MAGENTA;
            3'd5:    bar_rgb = BAR_RED;
            3'd6:    bar_rgb = BAR_BLUE;
            default: bar_rgb = BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/mipi_tx_pattern_rgb888.sv
// Test-pattern pixel generator: produces the RGB888 pixel pair for columns x0, x0+1
// of active line y, registered once.
module mipi_tx_pattern_rgb888
    import mipi_tx_pkg::*;
#(
    parameter int H_ACTIVE_PIX = 1280
) (
    input  logic        i_clk,
    input  logic [15:0] i_x0,
    input  logic [15:0] i_y,
    input  pattern_e    i_pattern,
    input  logic [23:0] i_solid,
    output logic [47:0] o_pix_p1
);

    localparam int          BAR_W   = (H_ACTIVE_PIX / 8 > 0) ? H_ACTIVE_PIX / 8 : 1;
    localparam logic [15:0] BAR_W16 = 16'(BAR_W);

    logic [15:0] w_x1;

    function automatic logic [23:0] pix_rgb(input logic [15:0] x, input logic [15:0] y,
                                            input pattern_e pat, input logic [23:0] solid);
        logic [15:0] bar;
        bar = x / BAR_W16;
        case (pat)
            PAT_BARS:  pix_rgb = (bar > 16'd7) ? BAR_BLACK : bar_rgb(bar[2:0]);
            PAT_RAMP:  pix_rgb = {3{x[7:0]}};
            PAT_SOLID: pix_rgb = solid;
            default:   pix_rgb = (((x ^ y) & 16'h0008) != 16'h0000) ? 24'hFFFFFF : 24'h000000;
        endcase
    endfunction

    assign w_x1 = i_x0 | 16'h0001;

    // p0 -> p1: pixel pair register
    always_ff @(posedge i_clk) begin
        o_pix_p1 <= {pix_rgb(w_x1, i_y, i_pattern, i_solid),
                     pix_rgb(i_x0, i_y, i_pattern, i_solid)};
    end

endmodule

// File: rtl/mipi_tx_frame_gen.sv
// Standalone CSI-2 TX frame generator: FSM with h/v counters, two-stage aligned
// control/data pipeline driving VSYNC/HSYNC/VALID/DATA.
module mipi_tx_frame_gen
    import mipi_tx_pkg::*;
#(
    parameter int H_ACTIVE_PIX = 1280,
    parameter int V_ACTIVE     = 720,
    parameter int HSA          = 4,
    parameter int HBP          = 16,
    parameter int HFP          = 16,
    parameter int VSA          = 1,
    parameter int VBP          = 4,
    parameter int VFP          = 4
) (
    input  logic        tx_pixel_clk,
    input  logic        tx_pixel_rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [23:0] solid_rgb,
    output logic        tx_VALID,
    output logic        tx_HSYNC,
    output logic        tx_VSYNC,
    output logic [63:0] tx_DATA,
    output logic [15:0] tx_HRES,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int          LT          = HSA + HBP + H_ACTIVE_PIX / 2 + HFP;
    localparam logic [15:0] H_LAST      = 16'(LT - 1);
    localparam logic [15:0] H_SYNC_W    = 16'(HSA);
    localparam logic [15:0] H_VLD_LO    = 16'(HSA + HBP);
    localparam logic [15:0] H_VLD_HI    = 16'(HSA + HBP + H_ACTIVE_PIX / 2);
    localparam logic [15:0] V_SYNC_END  = 16'(VSA - 1);
    localparam logic [15:0] V_BLANK_END = 16'(VSA + VBP - 1);
    localparam logic [15:0] V_ACT_LO    = 16'(VSA + VBP);
    localparam logic [15:0] V_ACT_END   = 16'(VSA + VBP + V_ACTIVE - 1);
    localparam logic [15:0] V_LAST      = 16'(VSA + VBP + V_ACTIVE + VFP - 1);

    state_e      r_state;
    state_e      w_state_nxt;
    logic        w_start;
    logic        w_frame_done;
    logic        w_line_end;
    logic [15:0] r_h_p0;
    logic [15:0] r_v_p0;
    pattern_e    r_pat;
    logic [23:0] r_solid;
    logic [15:0] r_frame_cnt;
    logic        r_busy;

    logic        w_vld_p0;
    logic        w_hs_p0;
    logic        w_vs_p0;
    logic [15:0] w_x0_p0;
    logic [15:0] w_y_p0;
    logic        r_vld_p1;
    logic        r_hs_p1;
    logic        r_vs_p1;
    logic [47:0] w_pix_p1;
    logic        r_vld_p2;
    logic        r_hs_p2;
    logic        r_vs_p2;
    logic [63:0] r_data_p2;

    assign w_line_end = (r_h_p0 == H_LAST);

    always_ff @(posedge tx_pixel_clk) begin
        if (tx_pixel_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_VSYNC;
                    w_start     = 1'b1;
                end
            end
            ST_VSYNC:  if (w_line_end && r_v_p0 == V_SYNC_END)  w_state_nxt = ST_VBLANK;
            ST_VBLANK: if (w_line_end && r_v_p0 == V_BLANK_END) w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_line_end && r_v_p0 == V_ACT_END)   w_state_nxt = ST_VFRONT;
            ST_VFRONT: begin
                if (w_line_end && r_v_p0 == V_LAST) begin
                    w_frame_done = 1'b1;
                    // Enable is only consulted here, so a drop never cuts a frame short.
                    if (enable) begin
                        w_state_nxt = ST_VSYNC;
                        w_start     = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge tx_pixel_clk) begin
        if (tx_pixel_rst) begin
            r_h_p0      <= '0;
            r_v_p0      <= '0;
            r_pat       <= PAT_BARS;
            r_solid     <= '0;
            r_frame_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_start) begin
                r_h_p0  <= '0;
                r_v_p0  <= '0;
                r_pat   <= pattern_e'(pattern_sel);
                r_solid <= solid_rgb;
            end else if (r_state != ST_IDLE) begin
                if (w_line_end) begin
                    r_h_p0 <= '0;
                    r_v_p0 <= (r_v_p0 == V_LAST) ? 16'd0 : r_v_p0 + 16'd1;
                end else begin
                    r_h_p0 <= r_h_p0 + 16'd1;
                end
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign w_vld_p0 = (r_state == ST_ACTIVE) && (r_h_p0 >= H_VLD_LO) && (r_h_p0 < H_VLD_HI);
    assign w_hs_p0  = (r_state != ST_IDLE) && (r_h_p0 < H_SYNC_W);
    assign w_vs_p0  = (r_state == ST_VSYNC);
    assign w_x0_p0  = (r_h_p0 - H_VLD_LO) << 1;
    assign w_y_p0   = r_v_p0 - V_ACT_LO;

    mipi_tx_pattern_rgb888 #(
        .H_ACTIVE_PIX (H_ACTIVE_PIX)
    ) u_pattern (
        .i_clk     (tx_pixel_clk),
        .i_x0      (w_x0_p0),
        .i_y       (w_y_p0),
        .i_pattern (r_pat),
        .i_solid   (r_solid),
        .o_pix_p1  (w_pix_p1)
    );

    // p0 -> p1: control delayed to match the pattern register
    always_ff @(posedge tx_pixel_clk) begin
        if (tx_pixel_rst) begin
            r_vld_p1 <= 1'b0;
            r_hs_p1  <= 1'b0;
            r_vs_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= w_vld_p0;
            r_hs_p1  <= w_hs_p0;
            r_vs_p1  <= w_vs_p0;
        end
    end

    // p1 -> p2: output registers, data gated to zero outside valid beats
    always_ff @(posedge tx_pixel_clk) begin
        if (tx_pixel_rst) begin
            r_vld_p2  <= 1'b0;
            r_hs_p2   <= 1'b0;
            r_vs_p2   <= 1'b0;
            r_data_p2 <= '0;
        end else begin
            r_vld_p2  <= r_vld_p1;
            r_hs_p2   <= r_hs_p1;
            r_vs_p2   <= r_vs_p1;
            r_data_p2 <= r_vld_p1 ? {16'h0000, w_pix_p1} : 64'h0;
        end
    end

    assign tx_VALID  = r_vld_p2;
    assign tx_HSYNC  = r_hs_p2;
    assign tx_VSYNC  = r_vs_p2;
    assign tx_DATA   = r_data_p2;
    assign tx_HRES   = 16'(H_ACTIVE_PIX);
    assign frame_cnt = r_frame_cnt;
    assign busy      = r_busy;

endmodule
